sdram_refresh_scheduler: RTL and testbench

SDRAM_REFRESH_SCHEDULER -- requirements
Module: sdram_refresh_scheduler

---
 rtl/sdram_pkg.sv | 19 +
 rtl/sdram_refresh_timer.sv | 25 ++
 rtl/sdram_refresh_scheduler.sv | 85 ++++++++
 tb/tb_sdram_refresh_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command payload, FSM state encoding and default refresh timing.
package sdram_pkg;

  localparam int REFRESH_INTERVAL = 780;
  localparam int MAX_POSTPONE     = 8;
  localparam int URGENT_THRESHOLD = 4;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
  } sdram_cmd_t;

  typedef enum logic {
    PASS     = 1'b0,
    REF_WAIT = 1'b1
  } ref_state_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter; one-cycle tick on wrap, held at 0 when disabled.
module sdram_refresh_timer #(
  parameter int INTERVAL = sdram_pkg::REFRESH_INTERVAL
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  output logic tick
);

  localparam int W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [W-1:0] LAST = W'(INTERVAL - 1);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         cnt <= '0;
    else if (!enable)  cnt <= '0;
    else if (tick)     cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// Tracks owed refreshes, requests them from the controller and gates the
// zero-latency command path while a refresh is pending or overdue.
module sdram_refresh_scheduler #(
  parameter int REFRESH_INTERVAL = sdram_pkg::REFRESH_INTERVAL,
  parameter int MAX_POSTPONE     = sdram_pkg::MAX_POSTPONE,
  parameter int URGENT_THRESHOLD = sdram_pkg::URGENT_THRESHOLD
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               init_done,
  input  logic                               cmd_in_valid,
  output logic                               cmd_in_ready,
  input  sdram_pkg::sdram_cmd_t              cmd_in_data,
  output logic                               cmd_out_valid,
  input  logic                               cmd_out_ready,
  output sdram_pkg::sdram_cmd_t              cmd_out_data,
  output logic                               ref_req,
  input  logic                               ref_ack,
  output logic [$clog2(MAX_POSTPONE+1)-1:0]  ref_debt,
  output logic                               ref_urgent,
  output logic                               ref_overflow
);
  import sdram_pkg::*;

  localparam int DW = $clog2(MAX_POSTPONE + 1);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_POSTPONE);
  localparam logic [DW-1:0] URG_D = DW'(URGENT_THRESHOLD);

  ref_state_e    state, state_nxt;
  logic [DW-1:0] debt_nxt;
  logic          tick, ack_cnt, open;

  sdram_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .enable (init_done),
    .tick   (tick)
  );

  // Only the ack that terminates a request we actually raised repays debt.
  assign ack_cnt    = ref_ack && (state == REF_WAIT);
  assign ref_urgent = (ref_debt >= URG_D);
  assign ref_req    = (state == REF_WAIT);

  // rstn is folded in so the handshake outputs drop immediately on reset assertion.
  assign open          = rstn && init_done && (state == PASS) && !ref_urgent;
  assign cmd_out_valid = cmd_in_valid && open;
  assign cmd_in_ready  = cmd_out_ready && open;
  assign cmd_out_data  = cmd_in_data;

  always_comb begin
    debt_nxt = ref_debt;
    if (tick && !ack_cnt) begin
      if (ref_debt != MAX_D) debt_nxt = ref_debt + 1'b1;
    end else if (ack_cnt && !tick && ref_debt != '0) begin
      debt_nxt = ref_debt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PASS:     if (init_done && (ref_urgent || (ref_debt != '0 && !cmd_in_valid)))
                  state_nxt = REF_WAIT;
      REF_WAIT: if (ref_ack) state_nxt = PASS;
      default:  state_nxt = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= PASS;
      ref_debt     <= '0;
      ref_overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      ref_debt <= debt_nxt;
      if (tick && ref_debt == MAX_D) ref_overflow <= 1'b1;
    end
  end

  a_no_cmd_during_ref: assert property (@(posedge clk) disable iff (!rstn)
    !(cmd_out_valid && ref_req));

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Randomized and directed checks of the refresh scheduler against a cycle-level behavioural model.
module tb_sdram_refresh_scheduler;
  import sdram_pkg::*;

  localparam int RI = 16;
  localparam int MP = 8;
  localparam int UT = 4;
  localparam int DW = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          rstn, init_done, cmd_in_valid, cmd_in_ready, cmd_out_valid, cmd_out_ready;
  logic          ref_req, ref_ack, ref_urgent, ref_overflow;
  sdram_cmd_t    cmd_in_data, cmd_out_data;
  logic [DW-1:0] ref_debt;

  always #5 clk = ~clk;

  sdram_refresh_scheduler #(
    .REFRESH_INTERVAL(RI), .MAX_POSTPONE(MP), .URGENT_THRESHOLD(UT)
  ) dut (
    .clk(clk), .rstn(rstn), .init_done(init_done),
    .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready), .cmd_in_data(cmd_in_data),
    .cmd_out_valid(cmd_out_valid), .cmd_out_ready(cmd_out_ready), .cmd_out_data(cmd_out_data),
    .ref_req(ref_req), .ref_ack(ref_ack), .ref_debt(ref_debt),
    .ref_urgent(ref_urgent), .ref_overflow(ref_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int xfers = 0;

  // Behavioural model: cycles elapsed since init, debt as a plain integer, "waiting" flag.
  int  m_elapsed, m_debt;
  bit  m_wait, m_ovf;
  // Snapshots of the combinational outputs within the cycle, plus their expectations.
  logic o_valid, o_ready, x_valid, x_ready;
  sdram_cmd_t o_data, x_data;

  task automatic model_reset();
    m_elapsed = 0; m_debt = 0; m_wait = 0; m_ovf = 0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; init_done = 1'b0; cmd_in_valid = 1'b0; cmd_out_ready = 1'b0; ref_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock cycle: drive, sample the pass-through outputs, advance DUT and model.
  task automatic cycle(input logic i, input logic cv, input logic cr, input logic a);
    bit tick, counted, open;
    int old_debt;
    init_done = i; cmd_in_valid = cv; cmd_out_ready = cr; ref_ack = a;
    open    = i && !m_wait && (m_debt < UT);
    x_valid = cv && open;
    x_ready = cr && open;
    x_data  = cmd_in_data;
    #1;
    o_valid = cmd_out_valid; o_ready = cmd_in_ready; o_data = cmd_out_data;
    if (cv && o_ready) xfers++;
    @(posedge clk);
    tick     = i && ((m_elapsed % RI) == RI - 1);
    counted  = a && m_wait;
    old_debt = m_debt;
    if (tick && old_debt == MP) m_ovf = 1;
    if (tick && !counted)      m_debt = (old_debt < MP) ? old_debt + 1 : MP;
    else if (counted && !tick) m_debt = old_debt - 1;
    if (m_wait) begin
      if (a) m_wait = 0;
    end else if (i && (old_debt >= UT || (old_debt > 0 && !cv))) begin
      m_wait = 1;
    end
    m_elapsed = i ? m_elapsed + 1 : 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; init_done = 1'b1; cmd_in_valid = 1'b1; cmd_out_ready = 1'b1; ref_ack = 1'b0;
    cmd_in_data = '0;
    #1;
    n_cmp++;
    if ({cmd_out_valid, cmd_in_ready, ref_req, ref_urgent, ref_overflow} !== 5'b0 || ref_debt !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b r=%b req=%b urg=%b ovf=%b debt=%0d, want all 0",
               cmd_out_valid, cmd_in_ready, ref_req, ref_urgent, ref_overflow, ref_debt);
    end
    apply_reset();
  endtask

  task automatic test_idle_refresh();
    apply_reset();
    for (int k = 0; k < 16; k++) cycle(1, 0, 1, 0);
    n_cmp++;
    if (ref_debt !== DW'(1) || ref_req !== 1'b0) begin
      n_bad++; $display("FAIL idle_debt: debt=%0d req=%b, want debt=1 req=0", ref_debt, ref_req);
    end
    cycle(1, 0, 1, 0);
    n_cmp++;
    if (ref_req !== 1'b1) begin n_bad++; $display("FAIL idle_req: req=%b, want 1", ref_req); end
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 1);
    n_cmp++;
    if (ref_debt !== '0 || ref_req !== 1'b0) begin
      n_bad++; $display("FAIL idle_ack: debt=%0d req=%b, want 0 0", ref_debt, ref_req);
    end
  endtask

  task automatic test_urgent_block();
    bit seen_block = 0;
    apply_reset();
    xfers = 0;
    for (int k = 0; k < 70; k++) begin
      cmd_in_data = sdram_cmd_t'($urandom);
      if (!seen_block && ref_debt == DW'(UT)) begin
        seen_block = 1;
        cycle(1, 1, 1, 0);
        n_cmp++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0 || ref_req !== 1'b1) begin
          n_bad++;
          $display("FAIL urgent_block: ready=%b valid=%b next_req=%b, want 0 0 1", o_ready, o_valid, ref_req);
        end
      end else begin
        cycle(1, 1, 1, 0);
      end
      n_cmp++;
      if (o_ready !== x_ready || o_valid !== x_valid || ref_debt !== DW'(m_debt) || ref_req !== m_wait) begin
        n_bad++;
        $display("FAIL urgent_model: k=%0d ready=%b/%b valid=%b/%b debt=%0d/%0d req=%b/%b",
                 k, o_ready, x_ready, o_valid, x_valid, ref_debt, m_debt, ref_req, m_wait);
      end
    end
    n_cmp++;
    if (!seen_block || xfers != 64) begin
      n_bad++; $display("FAIL urgent_count: block_seen=%0d transfers=%0d, want 1 64", seen_block, xfers);
    end
  endtask

  task automatic test_ack_on_tick();
    apply_reset();
    for (int k = 0; k < 31; k++) cycle(1, 0, 1, 0);
    n_cmp++;
    if (ref_req !== 1'b1 || ref_debt !== DW'(1)) begin
      n_bad++; $display("FAIL tick_ack_pre: req=%b debt=%0d, want 1 1", ref_req, ref_debt);
    end
    cycle(1, 0, 1, 1);
    n_cmp++;
    if (ref_req !== 1'b0 || ref_debt !== DW'(1)) begin
      n_bad++; $display("FAIL tick_ack: req=%b debt=%0d, want 0 1", ref_req, ref_debt);
    end
  endtask

  task automatic test_overflow();
    int guard = 0;
    apply_reset();
    for (int k = 0; k < 9 * RI; k++) cycle(1, 0, 1, 0);
    n_cmp++;
    if (ref_debt !== DW'(MP) || ref_overflow !== 1'b1 || ref_urgent !== 1'b1) begin
      n_bad++; $display("FAIL overflow_set: debt=%0d ovf=%b urg=%b, want 8 1 1", ref_debt, ref_overflow, ref_urgent);
    end
    while (m_debt != 0 && guard < 100) begin
      cycle(1, 0, 1, 1);
      guard++;
      n_cmp++;
      if (ref_debt !== DW'(m_debt) || ref_req !== m_wait) begin
        n_bad++; $display("FAIL repay_model: debt=%0d/%0d req=%b/%b", ref_debt, m_debt, ref_req, m_wait);
      end
    end
    n_cmp++;
    if (guard >= 100 || ref_debt !== '0 || ref_overflow !== 1'b1) begin
      n_bad++; $display("FAIL overflow_sticky: debt=%0d ovf=%b cycles=%0d, want 0 1", ref_debt, ref_overflow, guard);
    end
  endtask

  task automatic test_backpressure();
    sdram_cmd_t held;
    apply_reset();
    held = sdram_cmd_t'($urandom);
    cmd_in_data = held;
    xfers = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1, 1, 0, 0);
      n_cmp++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== held) begin
        n_bad++; $display("FAIL backpressure: ready=%b valid=%b data=%h, want 0 1 %h", o_ready, o_valid, o_data, held);
      end
    end
    cycle(1, 1, 1, 0);
    n_cmp++;
    if (xfers != 1 || o_data !== held) begin
      n_bad++; $display("FAIL backpressure_release: transfers=%0d data=%h, want 1 %h", xfers, o_data, held);
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    for (int k = 0; k < 3 * RI; k++) cycle(1, 0, 1, 0);
    n_cmp++;
    if (ref_debt !== DW'(3) || ref_req !== 1'b1) begin
      n_bad++; $display("FAIL wait_debt3: debt=%0d req=%b, want 3 1", ref_debt, ref_req);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (ref_req !== 1'b0 || ref_debt !== '0 || ref_overflow !== 1'b0 || cmd_in_ready !== 1'b0 || cmd_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: req=%b debt=%0d ovf=%b ready=%b valid=%b, want all 0",
                        ref_req, ref_debt, ref_overflow, cmd_in_ready, cmd_out_valid);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1, 1, 1, 1);
    n_cmp++;
    if (ref_debt !== '0 || ref_req !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++; $display("FAIL stale_ack: debt=%0d req=%b ready=%b, want 0 0 1", ref_debt, ref_req, o_ready);
    end
  endtask

  task automatic test_random();
    logic i, cv, cr, a;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      i  = ($urandom_range(0, 19) != 0);
      cv = ($urandom_range(0, 3) != 0);
      cr = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 5) == 0);
      cmd_in_data = sdram_cmd_t'($urandom);
      cycle(i, cv, cr, a);
      n_cmp++;
      if (o_valid !== x_valid || o_ready !== x_ready || o_data !== x_data) begin
        n_bad++;
        $display("FAIL rand_path: k=%0d valid=%b/%b ready=%b/%b data=%h/%h",
                 k, o_valid, x_valid, o_ready, x_ready, o_data, x_data);
      end
      n_cmp++;
      if (ref_debt !== DW'(m_debt) || ref_req !== m_wait || ref_overflow !== m_ovf || ref_urgent !== (m_debt >= UT)) begin
        n_bad++;
        $display("FAIL rand_state: k=%0d debt=%0d/%0d req=%b/%b ovf=%b/%b urg=%b",
                 k, ref_debt, m_debt, ref_req, m_wait, ref_overflow, m_ovf, ref_urgent);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_refresh();
    test_urgent_block();
    test_ack_on_tick();
    test_overflow();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
